start_pause_ctrl: RTL and testbench
===================================

# start_pause_ctrl

Control stage directly upstream of the 30-second down counter. It conditions the raw start/pause push button with a debouncer and one-pulse, and runs a Moore start/pause FSM. Its outputs are the counter's enable (`freeze` input) and a clear pulse that returns the counter to 30. It also consumes the counter's zero flag to detect the end of a countdown.

## Interface
- `DEB_LEN`, 4: debounce shift-register depth, in samples; ≥2.
- `LONG_PRESS`, 200: cycles the debounced button must stay held before a long-press clear fires; ≥2.
- `clk` input 1: sampling/system clock; same clock as the counter.
- `rst` input 1: asynchronous, active-high reset.
- `pb_start` input 1: raw, bouncing push button, active-high, asynchronous to `clk`.
- `cnt_zero` input 1: high when the counter value equals 0.
- `count_en` output 1: counter enable, drives the counter's `freeze` input; high only in RUN.
- `cnt_clr` output 1: one-cycle pulse; the top level uses it to reload the counter to 30.
- `state` output 2: current FSM state, for LEDs.
- `done_led` output 1: high in DONE.

## Operation
- **Input sync:** `pb_start` passes through a 2-flop synchronizer.
- **Debouncer:** `sr[DEB_LEN-1:0]` shifts in the synchronized sample each edge.
  - `pb_deb` is registered: it sets when `sr` is all ones, clears when `sr` is all zeros, and otherwise holds.
- **One-pulse:** registered `pb_press` = `pb_deb & ~pb_deb_d`.
  - Exactly one cycle per debounced press, regardless of hold length.
- **FSM states:** IDLE, RUN, PAUSE, DONE.
  - IDLE: `pb_press` → RUN.
  - RUN: `cnt_zero` → DONE; otherwise `pb_press` → PAUSE.
  - PAUSE: `pb_press` → RUN. `cnt_zero` is ignored.
  - DONE: `pb_press` → IDLE, with `cnt_clr` asserted for that transition's following cycle.
- **Outputs:** Moore decode of the state register; `count_en` = (state==RUN) and `done_led` = (state==DONE). Both are glitch-free.
- **Simultaneous `cnt_zero` and `pb_press` in RUN:** DONE wins and the press is discarded.
- **IDLE entered with `cnt_zero` high:** this cannot occur, because entry always clears the counter. No special handling is required.
- **Long press** (only with `LONG_PRESS_CLR_EN`, see Configuration):
  - `hold_cnt` counts cycles while `pb_deb`=1, saturating at `LONG_PRESS`, and clears when `pb_deb`=0.
  - When it reaches `LONG_PRESS-1`, `lp_fire` pulses once. Any state then → IDLE, with a `cnt_clr` pulse.
  - `lp_fire` has priority over `cnt_zero` and `pb_press` in the same cycle.
- **Width rules:**
  - `hold_cnt` is `$clog2(LONG_PRESS+1)` bits and never wraps.
  - The state encoding is 2 bits.

## Timing
- **Reset values:** `state`=IDLE, `count_en`=0, `cnt_clr`=0, `done_led`=0. `sr`, the synchronizer, `pb_deb`, `pb_deb_d`, `pb_press` and `hold_cnt` are all 0.
- **Press latency:** `pb_start` is stable high before edge 1.
  - Synchronizer output valid after edge 2.
  - `sr` is full after edge 2+`DEB_LEN`.
  - `pb_deb` rises at edge 3+`DEB_LEN`.
  - `pb_press` rises at edge 4+`DEB_LEN`.
  - `state`/`count_en` change at edge 5+`DEB_LEN`, which is 9 edges for `DEB_LEN`=4.
- **Bounce rejection:** any bounce shorter than `DEB_LEN` cycles produces no `pb_press`.
- **`cnt_zero` response:** `cnt_zero` sampled high in RUN drops `count_en` at the next edge. The counter saturates at 0 regardless.
- **`cnt_clr`:** registered; high for exactly one cycle, starting the edge after the state register enters IDLE from DONE or from a long press.
- **Reset mid-countdown:** `count_en` drops immediately (asynchronously). No `cnt_clr` is generated; the counter has its own reset.

## Configuration
- Macro: `START_PAUSE_LONG_PRESS_CLR_EN`.
- **Defined:** `hold_cnt` and the long-press clear path exist, and a hold of `LONG_PRESS` cycles aborts from any state to IDLE with `cnt_clr`.
- **Undefined:**
  - `hold_cnt` is not built and `LONG_PRESS` is unused.
  - The only route back to IDLE is a press in DONE, or reset.

## Structure
- **Shared package `stopwatch_pkg`:** state localparams IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, DONE=2'b11, plus the counter preset constant 30.
- **Sub-module `btn_debounce_onepulse`:**
  - Parameter: `DEB_LEN`.
  - Ports: `clk`, `rst`, `pb_raw`.
  - Outputs: `pb_deb`, `pb_press`.
  - Contents: synchronizer, shift register, one-pulse.
- **`start_pause_ctrl` itself:** the FSM, the long-press counter and the output decode.

## Test plan
- **Reset:** release `rst`, hold `pb_start`=0 for 20 cycles → `count_en`=0, `state`=00, `cnt_clr` never pulses.
- **Clean press (`DEB_LEN`=4):** `pb_start` high from edge 1 → `count_en`=1 exactly at edge 9. Second press → PAUSE, third press → RUN.
- **Bounce:** `pb_start` toggles 1,0,1,1,0,1 then stays high → exactly one `pb_press`, and `state` advances once.
- **Countdown end:** in RUN, assert `cnt_zero` together with `pb_press` → next state DONE and `done_led`=1. Then press → IDLE and `cnt_clr` high for one cycle.
- **Long press (macro defined, `LONG_PRESS`=200):** hold the button in RUN → PAUSE after the short press, then IDLE plus one `cnt_clr` at hold cycle 200. Continued holding produces no second clear.
- **Reset mid-RUN:** assert `rst` between edges → `count_en` low before the next edge, and all outputs at their reset values.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encoding and the counter preset value.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_e;

    // Value the down counter reloads to whenever cnt_clr pulses.
    localparam logic [4:0] CNT_PRESET = 5'd30;

endpackage : stopwatch_pkg

// File: rtl/start_pause_ctrl_if.sv
// Signal bundle between the start/pause controller and its surroundings.
// Level signals only: no handshake, every signal is sampled on each clk edge.
interface start_pause_ctrl_if;

    logic       pb_start;
    logic       cnt_zero;
    logic       count_en;
    logic       cnt_clr;
    logic [1:0] state;
    logic       done_led;

    modport master (
        output pb_start,
        output cnt_zero,
        input  count_en,
        input  cnt_clr,
        input  state,
        input  done_led
    );

    modport slave (
        input  pb_start,
        input  cnt_zero,
        output count_en,
        output cnt_clr,
        output state,
        output done_led
    );

endinterface : start_pause_ctrl_if

// File: rtl/btn_debounce_onepulse.sv
// Push-button conditioner: 2-flop synchronizer, shift-register debouncer with
// hysteresis, and a registered one-cycle press pulse.
module btn_debounce_onepulse #(
    parameter int DEB_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_raw,
    output logic pb_deb,
    output logic pb_press
);

    logic [1:0]         sync_q;
    logic [DEB_LEN-1:0] sr_q;
    logic               deb_q;
    logic               deb_dly_q;
    logic               press_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            sr_q      <= '0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pb_raw};
            sr_q   <= {sr_q[DEB_LEN-2:0], sync_q[1]};
            // Mixed samples hold the previous level, so short bounces are ignored.
            if (&sr_q) begin
                deb_q <= 1'b1;
            end else if (~|sr_q) begin
                deb_q <= 1'b0;
            end
            deb_dly_q <= deb_q;
            press_q   <= deb_q & ~deb_dly_q;
        end
    end

    assign pb_deb   = deb_q;
    assign pb_press = press_q;

endmodule : btn_debounce_onepulse

// File: rtl/start_pause_ctrl.sv
// Start/pause control for the 30 s down counter: button conditioning plus a Moore
// IDLE/RUN/PAUSE/DONE FSM. Define START_PAUSE_LONG_PRESS_CLR_EN for long-press abort.
module start_pause_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEB_LEN    = 4,
    parameter int LONG_PRESS = 200
) (
    input  logic                 clk,
    input  logic                 rst,
    start_pause_ctrl_if.slave    bus
);

    logic   pb_deb;
    logic   pb_press;
    logic   lp_fire;

    state_e state_q, state_d;
    logic   clr_d;
    logic   clr_req_q;
    logic   cnt_clr_q;
    logic   count_en_q;
    logic   done_led_q;

    btn_debounce_onepulse #(
        .DEB_LEN (DEB_LEN)
    ) u_btn (
        .clk      (clk),
        .rst      (rst),
        .pb_raw   (bus.pb_start),
        .pb_deb   (pb_deb),
        .pb_press (pb_press)
    );

`ifdef START_PAUSE_LONG_PRESS_CLR_EN
    localparam int             HW        = $clog2(LONG_PRESS + 1);
    localparam logic [HW-1:0]  HOLD_MAX  = HW'(LONG_PRESS);
    localparam logic [HW-1:0]  HOLD_FIRE = HW'(LONG_PRESS - 1);
    localparam logic [HW-1:0]  HOLD_ONE  = HW'(1);

    logic [HW-1:0] hold_cnt_q;

    // Saturating at LONG_PRESS keeps the fire compare from matching twice per hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q <= '0;
        end else if (!pb_deb) begin
            hold_cnt_q <= '0;
        end else if (hold_cnt_q != HOLD_MAX) begin
            hold_cnt_q <= hold_cnt_q + HOLD_ONE;
        end
    end

    assign lp_fire = pb_deb && (hold_cnt_q == HOLD_FIRE);
`else
    logic unused_lp;
    assign unused_lp = pb_deb ^ LONG_PRESS[0];
    assign lp_fire   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        if (lp_fire) begin
            state_d = IDLE;
            clr_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE:    if (pb_press) state_d = RUN;
                // End of countdown outranks a coincident press.
                RUN: begin
                    if (bus.cnt_zero)  state_d = DONE;
                    else if (pb_press) state_d = PAUSE;
                end
                PAUSE:   if (pb_press) state_d = RUN;
                DONE: begin
                    if (pb_press) begin
                        state_d = IDLE;
                        clr_d   = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            count_en_q <= 1'b0;
            done_led_q <= 1'b0;
            clr_req_q  <= 1'b0;
            cnt_clr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_en_q <= (state_d == RUN);
            done_led_q <= (state_d == DONE);
            clr_req_q  <= clr_d;
            cnt_clr_q  <= clr_req_q;
        end
    end

    assign bus.state    = state_q;
    assign bus.count_en = count_en_q;
    assign bus.done_led = done_led_q;
    assign bus.cnt_clr  = cnt_clr_q;

endmodule : start_pause_ctrl

// File: tb/tb_start_pause_ctrl.sv
// Bench for start_pause_ctrl: expected state transitions queued as presses are driven,
// checked by a monitor when the state output changes, plus cycle-exact latency checks.
module tb_start_pause_ctrl;
  import stopwatch_pkg::*;

  localparam int DEB_LEN    = 4;
  localparam int LONG_PRESS = 200;

  logic clk;
  logic rst;

  start_pause_ctrl_if bus ();

  start_pause_ctrl #(
    .DEB_LEN    (DEB_LEN),
    .LONG_PRESS (LONG_PRESS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks;
  int         errors;
  logic [1:0] exp_q[$];
  logic [1:0] prev_state;
  logic [1:0] mon_exp;
  bit         mon_en;
  int         clr_cnt;
  int         clr_run;
  int         exp_clr;
  logic [5:0] bounce_pat;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int hold);
    bus.pb_start = 1'b1;
    edges(hold);
    bus.pb_start = 1'b0;
    edges(12);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.state != prev_state) begin
        if (exp_q.size() == 0) begin
          check("state_unexpected", 32'(bus.state), 32'(prev_state));
        end else begin
          mon_exp = exp_q.pop_front();
          check("state_seq", 32'(bus.state), 32'(mon_exp));
          check("count_en_dec", 32'(bus.count_en), 32'(mon_exp == RUN));
          check("done_led_dec", 32'(bus.done_led), 32'(mon_exp == DONE));
        end
        prev_state = bus.state;
      end
      if (bus.cnt_clr) begin
        clr_run++;
        if (clr_run == 1) clr_cnt++;
      end else if (clr_run != 0) begin
        check("clr_width", 32'(clr_run), 32'd1);
        clr_run = 0;
      end
    end
  end

  // driver / stimulus
  initial begin
    checks     = 0;
    errors     = 0;
    mon_en     = 1'b0;
    clr_cnt    = 0;
    clr_run    = 0;
    exp_clr    = 0;
    prev_state = IDLE;
    bounce_pat = 6'b101101;
    rst        = 1'b1;
    bus.pb_start = 1'b0;
    bus.cnt_zero = 1'b0;

    edges(3);
    check("rst_state", 32'(bus.state), 32'(IDLE));
    check("rst_count_en", 32'(bus.count_en), 32'd0);
    check("rst_cnt_clr", 32'(bus.cnt_clr), 32'd0);
    check("rst_done_led", 32'(bus.done_led), 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    edges(20);
    check("idle_state", 32'(bus.state), 32'(IDLE));
    check("idle_count_en", 32'(bus.count_en), 32'd0);
    check("idle_no_clr", 32'(clr_cnt), 32'd0);

    // clean press: count_en must rise exactly at edge 5+DEB_LEN
    exp_q.push_back(RUN);
    bus.pb_start = 1'b1;
    edges(4 + DEB_LEN);
    check("lat_edge8_count_en", 32'(bus.count_en), 32'd0);
    edges(1);
    check("lat_edge9_count_en", 32'(bus.count_en), 32'd1);
    check("lat_edge9_state", 32'(bus.state), 32'(RUN));
    edges(1);
    bus.pb_start = 1'b0;
    edges(12);

    exp_q.push_back(PAUSE);
    press(10);
    check("press2_pause", 32'(bus.state), 32'(PAUSE));
    check("press2_count_en", 32'(bus.count_en), 32'd0);
    exp_q.push_back(RUN);
    press(10);
    check("press3_run", 32'(bus.state), 32'(RUN));

    // bouncing press advances exactly one state
    exp_q.push_back(PAUSE);
    for (int i = 5; i >= 0; i--) begin
      bus.pb_start = bounce_pat[i];
      edges(1);
    end
    bus.pb_start = 1'b1;
    edges(10);
    bus.pb_start = 1'b0;
    edges(12);
    check("bounce_pause", 32'(bus.state), 32'(PAUSE));
    exp_q.push_back(RUN);
    press(10);
    check("resume_run", 32'(bus.state), 32'(RUN));

    // countdown end coinciding with a press: DONE wins
    exp_q.push_back(DONE);
    bus.pb_start = 1'b1;
    edges(4 + DEB_LEN);
    bus.cnt_zero = 1'b1;
    edges(1);
    check("cz_state_done", 32'(bus.state), 32'(DONE));
    check("cz_done_led", 32'(bus.done_led), 32'd1);
    check("cz_count_en", 32'(bus.count_en), 32'd0);
    bus.pb_start = 1'b0;
    edges(12);
    check("done_hold", 32'(bus.state), 32'(DONE));

    exp_q.push_back(IDLE);
    exp_clr++;
    bus.pb_start = 1'b1;
    edges(5 + DEB_LEN);
    check("done_to_idle", 32'(bus.state), 32'(IDLE));
    check("clr_entry_edge", 32'(bus.cnt_clr), 32'd0);
    edges(1);
    check("clr_next_edge", 32'(bus.cnt_clr), 32'd1);
    bus.cnt_zero = 1'b0;
    edges(1);
    check("clr_after", 32'(bus.cnt_clr), 32'd0);
    bus.pb_start = 1'b0;
    edges(12);
    check("clr_total_done", 32'(clr_cnt), 32'(exp_clr));

`ifdef START_PAUSE_LONG_PRESS_CLR_EN
    // long press from RUN: short-press PAUSE, then abort to IDLE after LONG_PRESS cycles
    exp_q.push_back(RUN);
    press(10);
    exp_q.push_back(PAUSE);
    exp_q.push_back(IDLE);
    exp_clr++;
    bus.pb_start = 1'b1;
    edges(5 + DEB_LEN);
    check("lp_pause", 32'(bus.state), 32'(PAUSE));
    edges(LONG_PRESS - 3);
    check("lp_before_fire", 32'(bus.state), 32'(PAUSE));
    edges(1);
    check("lp_idle", 32'(bus.state), 32'(IDLE));
    check("lp_clr_entry_edge", 32'(bus.cnt_clr), 32'd0);
    edges(1);
    check("lp_clr_next_edge", 32'(bus.cnt_clr), 32'd1);
    edges(300);
    check("lp_single_clr", 32'(clr_cnt), 32'(exp_clr));
    check("lp_stay_idle", 32'(bus.state), 32'(IDLE));
    bus.pb_start = 1'b0;
    edges(12);
    check("lp_release_idle", 32'(bus.state), 32'(IDLE));
`endif

    // reset mid-RUN drops count_en before the next edge
    exp_q.push_back(RUN);
    press(10);
    check("pre_rst_count_en", 32'(bus.count_en), 32'd1);
    exp_q.push_back(IDLE);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_count_en", 32'(bus.count_en), 32'd0);
    check("midrst_state", 32'(bus.state), 32'(IDLE));
    check("midrst_done_led", 32'(bus.done_led), 32'd0);
    check("midrst_cnt_clr", 32'(bus.cnt_clr), 32'd0);
    edges(2);
    rst = 1'b0;
    edges(5);
    check("post_rst_idle", 32'(bus.state), 32'(IDLE));
    check("clr_total_final", 32'(clr_cnt), 32'(exp_clr));
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_start_pause_ctrl
